// File: rtl/t0_bus_decoder_pkg.sv
// Shared T0 bus definitions: both encoder and decoder import this so the flag index
// and polarity stay in lockstep.
package t0_bus_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_STRIDE = 1;
    localparam int DEF_CNT_W  = 16;
    localparam int FLAG_BIT   = DEF_WIDTH;

    typedef enum logic {
        W_LOAD,
        W_INC
    } word_kind_e;

    typedef logic [FLAG_BIT:0] enc_word_t;

    // Flag high means the lines carry a fresh address; low means they were frozen.
    function automatic word_kind_e kind_of(input logic flag);
        return flag ? W_LOAD : W_INC;
    endfunction

endpackage

// File: rtl/t0_bus_decoder_if.sv
// Encoded-link bundle between a T0 word source (master) and the decoder (slave).
interface t0_bus_decoder_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    // en is a plain valid with no back-pressure: the decoder accepts one word on
    // every rising edge where en=1, so the source never waits for a ready.
    logic             en;
    logic [WIDTH:0]   bus_in;
    logic             viol_clr;
    logic [WIDTH-1:0] addr_out;
    logic             addr_vld;
    logic             viol;
    logic [CNT_W-1:0] load_cnt;
    logic [CNT_W-1:0] inc_cnt;
    logic [CNT_W-1:0] max_run;
    logic [CNT_W-1:0] run_len;

    modport master (
        output en, bus_in, viol_clr,
        input  addr_out, addr_vld, viol, load_cnt, inc_cnt, max_run, run_len
    );

    modport slave (
        input  en, bus_in, viol_clr,
        output addr_out, addr_vld, viol, load_cnt, inc_cnt, max_run, run_len
    );

endinterface

// File: rtl/t0_bus_decoder_sat_counter.sv
// Saturating up-counter with a synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge ck) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (inc && (r_count != CNT_MAX)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/t0_bus_decoder.sv
// T0 bus receiver: rebuilds the address stream from load/frozen words, flags frozen
// words whose lines moved, and keeps saturating link statistics.
module t0_bus_decoder
    import t0_bus_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STRIDE = DEF_STRIDE,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic             ck,
    input  logic             rst,
    t0_bus_decoder_if.slave  bus
);

    localparam logic [WIDTH-1:0] STEP    = WIDTH'(STRIDE);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    word_kind_e       w_kind;
    logic             w_load;
    logic             w_inc;
    logic             w_viol_set;
    logic [WIDTH-1:0] w_lines;
    logic [CNT_W-1:0] w_run_len;
    logic [CNT_W-1:0] w_run_next;
    logic [CNT_W-1:0] w_load_cnt;
    logic [CNT_W-1:0] w_inc_cnt;

    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_bus_last;
    logic             r_vld;
    logic             r_viol;
    logic [CNT_W-1:0] r_max_run;

    assign w_kind     = kind_of(bus.bus_in[WIDTH]);
    assign w_lines    = bus.bus_in[WIDTH-1:0];
    assign w_load     = bus.en && (w_kind == W_LOAD);
    assign w_inc      = bus.en && (w_kind == W_INC);
    // A frozen word must repeat the last loaded lines; any toggle is a protocol error.
    assign w_viol_set = w_inc && (w_lines != r_bus_last);
    assign w_run_next = (w_run_len == CNT_MAX) ? CNT_MAX : w_run_len + CNT_W'(1);

    sat_counter #(.CNT_W(CNT_W)) u_load_cnt (
        .ck    (ck),
        .rst   (rst),
        .clear (1'b0),
        .inc   (w_load),
        .count (w_load_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_inc_cnt (
        .ck    (ck),
        .rst   (rst),
        .clear (1'b0),
        .inc   (w_inc),
        .count (w_inc_cnt)
    );

    // Run tracker: a load word ends the current run of increment words.
    sat_counter #(.CNT_W(CNT_W)) u_run_len (
        .ck    (ck),
        .rst   (rst),
        .clear (w_load),
        .inc   (w_inc),
        .count (w_run_len)
    );

    always_ff @(posedge ck) begin
        if (rst) begin
            r_addr     <= '0;
            r_bus_last <= '0;
            r_vld      <= 1'b0;
            r_viol     <= 1'b0;
            r_max_run  <= '0;
        end else begin
            r_vld <= bus.en;
            if (w_load) begin
                r_addr     <= w_lines;
                r_bus_last <= w_lines;
            end else if (w_inc) begin
                r_addr <= r_addr + STEP;
                if (w_run_next > r_max_run) begin
                    r_max_run <= w_run_next;
                end
            end
            // viol_clr is a side-band control that acts even on idle cycles; a new violation wins.
            if (w_viol_set) begin
                r_viol <= 1'b1;
            end else if (bus.viol_clr) begin
                r_viol <= 1'b0;
            end
        end
    end

    assign bus.addr_out = r_addr;
    assign bus.addr_vld = r_vld;
    assign bus.viol     = r_viol;
    assign bus.load_cnt = w_load_cnt;
    assign bus.inc_cnt  = w_inc_cnt;
    assign bus.max_run  = r_max_run;
    assign bus.run_len  = w_run_len;

endmodule

// File: doc/t0_bus_decoder.md
Name: t0_bus_decoder

Overview:
- Receiver side of the T0 (zero-transition) address bus.
- Takes the encoded bus word (WIDTH data lines plus one load flag) and rebuilds the original address stream.
  - Flag high: the bus lines carry a new address.
  - Flag low: the encoder froze the lines, and the address is the previous address plus STRIDE.
- Sits at the memory/peripheral end of the encoded link.
- Also gives protocol-violation detection and link statistics for power-analysis runs.

Parameters:
- WIDTH, 8, address/bus line width.
- STRIDE, 1, address increment implied by a frozen word (modulo 2^WIDTH).
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- ck  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- en  in  1  encoded word valid this cycle; no state change when low.
- bus_in  in  WIDTH+1  encoded word: bit WIDTH is the load flag, bits WIDTH-1:0 are the bus lines.
- viol_clr  in  1  clears the viol sticky bit.
- addr_out  out  WIDTH  decoded address (registered).
- addr_vld  out  1  one-cycle pulse: addr_out was updated on the previous edge.
- viol  out  1  sticky: a frozen word was received while the bus lines toggled.
- load_cnt  out  CNT_W  number of load words decoded, saturating.
- inc_cnt  out  CNT_W  number of increment words decoded, saturating.
- max_run  out  CNT_W  longest run of consecutive increment words, saturating.

Behaviour:
- Reset (rst=1 at an edge) forces the following to 0:
  - addr_out, addr_vld, viol, load_cnt, inc_cnt, max_run.
  - Internal bus_last and run_len.
- Reset has priority over en and viol_clr, including mid-stream. This matches the encoder, whose bus and flag also reset to 0.
- Latency: one cycle. A word sampled at edge k appears on addr_out after edge k, and addr_vld is high for that same cycle.
- en=0: all registers hold and addr_vld=0 next cycle.
- en=1, load word (flag=1):
  - addr_out <= bus lines.
  - bus_last <= bus lines.
  - load_cnt +1.
  - run_len <= 0.
- en=1, increment word (flag=0):
  - addr_out <= addr_out + STRIDE, truncated to WIDTH bits. Wrap is silent: 0xFF + 1 gives 0x00.
  - inc_cnt +1.
  - run_len <= run_len + 1 (saturating).
  - max_run <= max(max_run, run_len+1).
  - bus_last is unchanged.
- Violation:
  - Condition: en=1, flag=0 and bus lines != bus_last.
  - Effect: viol <= 1. The address is still incremented; the bus lines are ignored for decoding.
- viol_clr=1 clears viol in the next cycle. If a violation occurs in the same cycle as viol_clr, the set wins and viol stays 1.
- Statistics counters saturate at 2^CNT_W-1 and never wrap.
- First word after reset with flag=0 decodes to STRIDE (0 + STRIDE). Bus lines must equal 0 in this case, otherwise viol is set.
- Back-to-back load words with identical lines are legal. They are counted as loads and raise no violation.
- No FSM beyond the run tracker. Word kind is an enum: W_LOAD, W_INC. This decode is combinational from bus_in.

Decomposition:
- Package t0_bus_pkg holds:
  - Default parameters: WIDTH=8, STRIDE=1.
  - FLAG_BIT = WIDTH, the load-flag index.
  - The word_kind_e enum {W_LOAD, W_INC}.
  - The encoded-word type (WIDTH+1 bits).
- The package is shared with the team's T0 encoder so both ends agree on flag index and polarity.
- One sub-module: sat_counter (parameter CNT_W; inputs clear, inc; saturating output). It is instantiated for load_cnt, inc_cnt and run_len.

Test Plan:
- Reset then en=1 with words 1_0x10, 0_0x10, 0_0x10 → addr_out sequence 0x10, 0x11, 0x12; addr_vld pulses 3 times; load_cnt=1, inc_cnt=2, max_run=2, viol=0.
- Wrap: load 1_0xFE, then two increment words 0_0xFE → addr_out 0xFE, 0xFF, 0x00; viol=0.
- Violation: load 1_0x20, then 0_0x21 → addr_out 0x21 (incremented) and viol=1 the next cycle. viol_clr=1 alone → viol=0. viol_clr together with another violating word → viol stays 1.
- Stall: load 1_0x40, en=0 for 3 cycles with garbage on bus_in, then 0_0x40 → addr_out holds 0x40 during the stall with addr_vld=0, then becomes 0x41; counters are unaffected by the stall.
- Reset mid-run: load 0x30, two increments, assert rst for one cycle, then 0_0x00 → all outputs 0 after reset; the next word gives addr_out=0x01 and viol=0.
- Saturation (CNT_W=2): five increment words → inc_cnt=3, max_run=3.
